counterdiv_multi: RTL and testbench

//  Multi-channel programmable tick generator. Each channel counts 0..max and pulses tick when the count equals max.

---
 rtl/counterdiv_multi.sv | 111 +++++++++++
 tb/tb_counterdiv_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/counterdiv_multi.sv
// rtl/counterdiv_multi.sv - multi-channel programmable tick generator with shadowed reload
module counterdiv_multi #(
  parameter int               NCH       = 4,
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_MAX = '0,
  parameter bit               AUTOSTART = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  en,
  input  logic [NCH-1:0]                        ch_en,
  input  logic [NCH-1:0]                        restart,
  input  logic                                  ld_valid,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ld_ch,
  input  logic [WIDTH-1:0]                      ld_max,
  input  logic                                  ld_oneshot,
  output logic [NCH-1:0]                        tick,
  output logic [NCH*WIDTH-1:0]                  count,
  output logic [NCH-1:0]                        running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state [NCH];
  logic [WIDTH-1:0] r_count [NCH];
  logic [WIDTH-1:0] r_amax  [NCH];
  logic [WIDTH-1:0] r_smax  [NCH];
  logic [NCH-1:0]   r_amode;
  logic [NCH-1:0]   r_smode;
  logic [NCH-1:0]   r_pend;

  logic [NCH-1:0]   w_adv;
  logic [NCH-1:0]   w_tick;
  logic [NCH-1:0]   w_ld;
  logic [NCH-1:0]   w_apply;

  // Per-channel decode: advance, terminal count, load hit, and whether a pending reload may land now.
  // tick is gated by reset so every output except running reads zero while held in reset.
  always_comb begin
    w_adv   = '0;
    w_tick  = '0;
    w_ld    = '0;
    w_apply = '0;
    running = '0;
    count   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_adv[i]   = en & ch_en[i] & (r_state[i] == S_RUN);
      w_tick[i]  = reset & w_adv[i] & (r_count[i] == r_amax[i]);
      w_ld[i]    = ld_valid & (int'(ld_ch) == i) & (int'(ld_ch) < NCH);
      w_apply[i] = restart[i] | (r_state[i] != S_RUN) | w_tick[i];
      running[i] = (r_state[i] == S_RUN);
      count[i*WIDTH +: WIDTH] = r_count[i];
    end
    tick = w_tick;
  end

  // Channel state machines plus active/shadow max; a RUN channel only swaps max at wrap or restart,
  // so the period in flight always finishes with the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= AUTOSTART ? S_RUN : S_IDLE;
        r_count[i] <= '0;
        r_amax[i]  <= RESET_MAX;
        r_smax[i]  <= '0;
      end
      r_amode <= '0;
      r_smode <= '0;
      r_pend  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_apply[i]) begin
          if (w_ld[i]) begin
            r_amax[i]  <= ld_max;
            r_amode[i] <= ld_oneshot;
          end else if (r_pend[i]) begin
            r_amax[i]  <= r_smax[i];
            r_amode[i] <= r_smode[i];
          end
          r_pend[i] <= 1'b0;
        end else if (w_ld[i]) begin
          r_smax[i]  <= ld_max;
          r_smode[i] <= ld_oneshot;
          r_pend[i]  <= 1'b1;
        end

        if (restart[i]) begin
          r_count[i] <= '0;
          r_state[i] <= S_RUN;
        end else begin
          case (r_state[i])
            S_RUN: begin
              if (w_tick[i]) begin
                r_count[i] <= '0;
                if (r_amode[i]) r_state[i] <= S_DONE;
              end else if (w_adv[i]) begin
                r_count[i] <= r_count[i] + 1'b1;
              end
            end
            default: r_count[i] <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_counterdiv_multi.sv
// tb/tb_counterdiv_multi.sv - scoreboard bench for counterdiv_multi
module tb_counterdiv_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  ch_en;
  logic [3:0]  restart;
  logic        ld_valid;
  logic [1:0]  ld_ch;
  logic [7:0]  ld_max;
  logic        ld_oneshot;
  logic [3:0]  tick;
  logic [31:0] count;
  logic [3:0]  running;

  logic        en3 = 1'b1;
  logic [2:0]  ch_en3 = 3'b111;
  logic [2:0]  restart3 = 3'b000;
  logic        ld_valid3;
  logic [1:0]  ld_ch3;
  logic [7:0]  ld_max3;
  logic        ld_os3;
  logic [2:0]  tick3;
  logic [23:0] count3;
  logic [2:0]  running3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  counterdiv_multi #(.NCH(4), .WIDTH(8), .RESET_MAX(8'd3), .AUTOSTART(1'b1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .ch_en(ch_en), .restart(restart),
    .ld_valid(ld_valid), .ld_ch(ld_ch), .ld_max(ld_max), .ld_oneshot(ld_oneshot),
    .tick(tick), .count(count), .running(running)
  );

  counterdiv_multi #(.NCH(3), .WIDTH(8), .RESET_MAX(8'd3), .AUTOSTART(1'b1)) u_dut3 (
    .clk(clk), .reset(reset), .en(en3), .ch_en(ch_en3), .restart(restart3),
    .ld_valid(ld_valid3), .ld_ch(ld_ch3), .ld_max(ld_max3), .ld_oneshot(ld_os3),
    .tick(tick3), .count(count3), .running(running3)
  );

  typedef struct {
    logic [3:0]  tk;
    logic [31:0] cn;
    logic [3:0]  rn;
    logic [2:0]  tk3;
    logic [23:0] cn3;
    logic [2:0]  rn3;
  } exp_t;

  exp_t sb[$];

  logic [7:0] m_cnt [4];
  logic [7:0] m_max [4];
  logic [7:0] m_smax[4];
  logic       m_os  [4];
  logic       m_sos [4];
  logic       m_pend[4];
  int         m_st  [4];
  logic [7:0] c3;
  logic [3:0] last_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 8'd0; m_max[i] = 8'd3; m_smax[i] = 8'd0;
      m_os[i] = 1'b0; m_sos[i] = 1'b0; m_pend[i] = 1'b0; m_st[i] = 1;
    end
    c3 = 8'd0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.tk[i] = reset && en && ch_en[i] && (m_st[i] == 1) && (m_cnt[i] == m_max[i]);
      e.cn[i*8 +: 8] = m_cnt[i];
      e.rn[i] = (m_st[i] == 1);
    end
    e.tk3 = (reset && c3 == 8'd3) ? 3'b111 : 3'b000;
    e.cn3 = {c3, c3, c3};
    e.rn3 = 3'b111;
    return e;
  endfunction

  task automatic model_step();
    logic adv, tk, ld, apply;
    if (!reset) return;
    c3 = (c3 == 8'd3) ? 8'd0 : c3 + 8'd1;
    for (int i = 0; i < 4; i++) begin
      adv   = en && ch_en[i] && (m_st[i] == 1);
      tk    = adv && (m_cnt[i] == m_max[i]);
      ld    = ld_valid && (int'(ld_ch) == i);
      apply = restart[i] || (m_st[i] != 1) || tk;
      if (restart[i]) begin
        m_cnt[i] = 8'd0; m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        if (tk) begin
          m_cnt[i] = 8'd0;
          if (m_os[i]) m_st[i] = 2;
        end else if (adv) m_cnt[i] = m_cnt[i] + 8'd1;
      end else m_cnt[i] = 8'd0;
      if (apply) begin
        if (ld) begin m_max[i] = ld_max; m_os[i] = ld_oneshot; end
        else if (m_pend[i]) begin m_max[i] = m_smax[i]; m_os[i] = m_sos[i]; end
        m_pend[i] = 1'b0;
      end else if (ld) begin
        m_smax[i] = ld_max; m_sos[i] = ld_oneshot; m_pend[i] = 1'b1;
      end
    end
  endtask

  // One clock cycle: push the expectation for the current inputs, compare at negedge, advance the model at posedge.
  task automatic cyc();
    exp_t g;
    sb.push_back(model_out());
    @(negedge clk);
    g = sb.pop_front();
    chk("tick", 32'(tick), 32'(g.tk));
    chk("count", count, g.cn);
    chk("running", 32'(running), 32'(g.rn));
    chk("tick3", 32'(tick3), 32'(g.tk3));
    chk("count3", 32'(count3), 32'(g.cn3));
    chk("running3", 32'(running3), 32'(g.rn3));
    last_tick = tick;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, second;
    reset = 1'b0; en = 1'b1; ch_en = 4'hF; restart = 4'h0;
    ld_valid = 1'b0; ld_ch = 2'd0; ld_max = 8'd0; ld_oneshot = 1'b0;
    ld_valid3 = 1'b0; ld_ch3 = 2'd3; ld_max3 = 8'd0; ld_os3 = 1'b0;
    last_tick = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cyc();
    reset = 1'b1;

    // periodic ticks with max 3, out-of-range load on the 3-channel instance must do nothing
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (last_tick[0]) begin n++; chk("t1_tick_cycle", 32'(k % 4), 32'd0); end
    end
    chk("t1_ticks", 32'(n), 32'd3);
    cyc();

    // reload ch1 mid-period: old period finishes, then period 10
    ld_valid = 1'b1; ld_ch = 2'd1; ld_max = 8'd9; ld_oneshot = 1'b0;
    ld_valid3 = 1'b1; ld_ch3 = 2'd3; ld_max3 = 8'd0;
    cyc();
    ld_valid = 1'b0; ld_valid3 = 1'b0;
    first = -1; second = -1;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (last_tick[1]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
    end
    chk("t2_first", 32'(first), 32'd2);
    chk("t2_period", 32'(second - first), 32'd10);

    // one-shot ch2 with max 2 via restart
    ld_valid = 1'b1; ld_ch = 2'd2; ld_max = 8'd2; ld_oneshot = 1'b1;
    cyc();
    ld_valid = 1'b0; restart = 4'b0100;
    cyc();
    restart = 4'h0;
    n = 0; first = -1;
    for (int k = 1; k <= 23; k++) begin
      cyc();
      if (last_tick[2]) begin n++; if (first < 0) first = k; end
    end
    chk("t3_ticks", 32'(n), 32'd1);
    chk("t3_at", 32'(first), 32'd3);
    chk("t3_running", 32'(running[2]), 32'd0);
    chk("t3_count", 32'(count[23:16]), 32'd0);

    // freeze ch0 with ch_en then global en
    for (int k = 0; k < 8 && count[7:0] != 8'd2; k++) cyc();
    chk("t4_reach", 32'(count[7:0]), 32'd2);
    ch_en[0] = 1'b0;
    repeat (5) cyc();
    ch_en[0] = 1'b1; en = 1'b0;
    repeat (3) cyc();
    chk("t4_frozen", 32'(count[7:0]), 32'd2);
    en = 1'b1;
    repeat (4) cyc();

    // asynchronous reset mid-count
    for (int k = 0; k < 8 && count[7:0] != 8'd2; k++) cyc();
    chk("t5_reach", 32'(count[7:0]), 32'd2);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("t5_count", count, 32'd0);
    chk("t5_tick", 32'(tick), 32'd0);
    chk("t5_running", 32'(running), 32'hF);
    repeat (2) cyc();
    reset = 1'b1;
    n = 0;
    for (int k = 1; k <= 8; k++) begin cyc(); if (last_tick[1]) n++; end
    chk("t5_ch1_ticks", 32'(n), 32'd2);

    // max 0 periodic on ch3: tick every enabled cycle
    ld_valid = 1'b1; ld_ch = 2'd3; ld_max = 8'd0; ld_oneshot = 1'b0;
    cyc();
    ld_valid = 1'b0;
    repeat (5) cyc();
    n = 0;
    for (int k = 1; k <= 8; k++) begin cyc(); if (last_tick[3]) n++; end
    chk("t6_max0_ticks", 32'(n), 32'd8);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      en = ($urandom_range(0, 7) != 0);
      ch_en = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      restart = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_ch = 2'($urandom_range(0, 3));
      ld_max = 8'($urandom_range(0, 5));
      ld_oneshot = ($urandom_range(0, 2) == 0);
      ld_valid3 = ($urandom_range(0, 1) == 0);
      ld_max3 = 8'($urandom_range(0, 255));
      cyc();
    end
    en = 1'b1; ch_en = 4'hF; restart = 4'h0; ld_valid = 1'b0; ld_valid3 = 1'b0;
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
